// File: rtl/xor_i8_i8_i8_unit.sv
// Bitwise XOR leaf primitive (xor, i8 x i8 -> i8).
// The result is combinational by default. Setting OUT_REG=1 adds one
// registered stage that is cleared by the synchronous active-low reset.
// This block has no handshake: a new operand pair is accepted every cycle,
// and y is always a function of the inputs (OUT_REG=0) or of the inputs
// from the previous edge (OUT_REG=1).
module xor_i8_i8_i8_unit #(
    parameter int WIDTH   = 8,
    parameter bit OUT_REG = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Each bit is independent: no carry, no sign handling.
    logic [WIDTH-1:0] xor_result;

    assign xor_result = a ^ b;

    generate
        if (OUT_REG) begin : g_out_reg
            logic [WIDTH-1:0] y_q;

            // Output stage: clear on reset, otherwise capture the XOR.
            // The in-flight value is discarded when reset is asserted.
            always_ff @(posedge clock) begin
                if (!reset) begin
                    y_q <= '0;
                end else begin
                    y_q <= xor_result;
                end
            end

            assign y = y_q;
        end else begin : g_out_comb
            // In the combinational configuration, clock and reset exist
            // only so the port list matches the pipelined siblings.
            logic unused_clock_reset;

            assign unused_clock_reset = clock ^ reset;
            assign y = xor_result;
        end
    endgenerate

endmodule

// File: tb/tb_xor_i8_i8_i8_unit.sv
// Self-checking bench for xor_i8_i8_i8_unit.
// It builds both configurations side by side: a combinational instance
// and a registered instance. Both are driven from the same operands, and
// each has its own reset.
module tb_xor_i8_i8_i8_unit;

    logic       clock;
    logic       reset_c;
    logic       reset_r;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y_c;
    logic [7:0] y_r;

    int n_cmp = 0;
    int n_err = 0;

    // Expected registered outputs, one entry per applied operand pair.
    logic [7:0] exp_q[$];

    xor_i8_i8_i8_unit #(.WIDTH(8), .OUT_REG(1'b0)) dut_c (
        .clock (clock),
        .reset (reset_c),
        .a     (a),
        .b     (b),
        .y     (y_c)
    );

    xor_i8_i8_i8_unit #(.WIDTH(8), .OUT_REG(1'b1)) dut_r (
        .clock (clock),
        .reset (reset_r),
        .a     (a),
        .b     (b),
        .y     (y_r)
    );

    // Clock generation: 10-unit period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: XOR is addition without carries, so
    // x ^ z == x + z - 2*(x & z).
    function automatic logic [7:0] ref_xor(input logic [7:0] x, input logic [7:0] z);
        int s;
        s = int'(x) + int'(z) - 2 * int'(x & z);
        return s[7:0];
    endfunction

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive a new operand pair and resets on the falling edge.
    // Check the combinational output in the same cycle, and queue the
    // value the registered output must show after the next rising edge.
    task automatic apply(input logic [7:0] av, input logic [7:0] bv,
                         input logic rc, input logic rr);
        @(negedge clock);
        a       = av;
        b       = bv;
        reset_c = rc;
        reset_r = rr;
        exp_q.push_back(rr ? ref_xor(av, bv) : 8'h00);
        #1;
        check_eq("comb", y_c, ref_xor(av, bv));
    endtask

    // Advance one rising edge and check the registered output.
    task automatic tick(input string tag);
        logic [7:0] e;
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got 0x%02h expected <empty queue>", tag, y_r);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, y_r, e);
        end
    endtask

    initial begin
        a       = 8'd3;
        b       = 8'd12;
        reset_c = 1'b0;
        reset_r = 1'b0;

        // Reset phase with a=3, b=12 held throughout.
        apply(8'd3, 8'd12, 1'b0, 1'b0);
        tick("reg_reset");
        check_eq("comb_in_reset", y_c, 8'd15);

        // First cycle after reset.
        apply(8'd3, 8'd12, 1'b1, 1'b1);
        tick("reg_after_reset");
        check_eq("comb_after_reset", y_c, 8'd15);

        // Directed patterns, including the identities.
        apply(8'hFF, 8'h00, 1'b1, 1'b1);
        tick("reg_ff_00");
        apply(8'hA5, 8'hA5, 1'b1, 1'b1);
        check_eq("comb_a_xor_a", y_c, 8'h00);
        tick("reg_a5_a5");
        apply(8'hAA, 8'h55, 1'b1, 1'b1);
        check_eq("comb_aa_55", y_c, 8'hFF);
        tick("reg_aa_55");
        apply(8'h3C, 8'hFF, 1'b1, 1'b1);
        check_eq("comb_not_a", y_c, 8'hC3);
        tick("reg_not_a");

        // Combinational instance ignores reset and follows inputs in the same cycle.
        apply(8'h0F, 8'hF0, 1'b0, 1'b1);
        check_eq("comb_reset_ignored", y_c, 8'hFF);
        #2;
        a = 8'h00;
        #1;
        check_eq("comb_same_cycle", y_c, 8'hF0);
        exp_q[exp_q.size() - 1] = 8'hF0;
        tick("reg_mid_cycle_change");

        // Registered instance: clear, then latency and mid-stream reset.
        apply(8'h77, 8'h11, 1'b1, 1'b0);
        tick("reg_cleared");
        apply(8'd3, 8'd12, 1'b1, 1'b1);
        check_eq("reg_before_edge_n", y_r, 8'h00);
        tick("reg_after_edge_n");
        check_eq("reg_value_15", y_r, 8'd15);
        apply(8'h5A, 8'h0F, 1'b1, 1'b0);
        tick("reg_mid_stream_reset");

        // Randomized traffic with occasional registered resets.
        for (int i = 0; i < 300; i++) begin
            apply(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 15) != 0));
            tick("reg_rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
